// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit holding the architectural HI/LO registers.
// Define MULDIV_FAST_ZERO_EN to finish zero-operand multiplies and divide-by-zero in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_fastZero;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_accNext;
  logic [WIDTH+1:0]     w_shift;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_borrow;
  logic [WIDTH:0]       w_remNext;
  logic [WIDTH-1:0]     w_quoNext;

  assign w_accept = start && !op[1] && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CNT_W'(1));

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fastZero = op[0] ? (b == '0) : (a == '0 || b == '0);
`else
  assign w_fastZero = 1'b0;
`endif

  // Shift-add step: conditionally add the multiplicand to the upper half, then shift right.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
  assign w_accNext = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: the extra top bit of the trial difference exposes the borrow.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {2'b00, r_divisor};
  assign w_borrow  = w_diff[WIDTH+1];
  assign w_remNext = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_stateNext = w_fastZero ? DONE : (op[0] ? DIV : MUL);
        else          w_stateNext = IDLE;
      end
      MUL, DIV: if (w_last) w_stateNext = DONE;
      default:  w_stateNext = IDLE;
    endcase
  end

  // HI/LO change only on the edge that enters DONE; working registers reload on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_dbz <= 1'b0;
      if (w_accept) begin
        r_cnt     <= CNT_W'(WIDTH);
        r_acc     <= {{WIDTH{1'b0}}, b};
        r_mcand   <= a;
        r_rem     <= '0;
        r_quo     <= a;
        r_divisor <= b;
        if (w_fastZero) begin
          if (op[0]) begin
            r_hi  <= a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= '0;
            r_lo <= '0;
          end
        end
      end else if (r_state == MUL) begin
        r_acc <= w_accNext;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) {r_hi, r_lo} <= w_accNext;
      end else if (r_state == DIV) begin
        r_rem <= w_remNext;
        r_quo <= w_quoNext;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_hi  <= w_remNext[WIDTH-1:0];
          r_lo  <= w_quoNext;
          r_dbz <= (r_divisor == '0);
        end
      end
    end
  end

  assign busy        = (r_state == MUL) || (r_state == DIV);
  assign done        = (r_state == DONE);
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level result/timing model compared every cycle,
// plus hand-computed literal checks for the directed vectors.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_ZERO_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b11;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checkCount = 0;
  int errorCount = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: results straight from the operator definitions.
  function automatic logic [WIDTH-1:0] expHi(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    if (!o[0]) return p[2*WIDTH-1:WIDTH];
    if (y == '0) return x;
    return x % y;
  endfunction

  function automatic logic [WIDTH-1:0] expLo(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    if (!o[0]) return p[WIDTH-1:0];
    if (y == '0) return '1;
    return x / y;
  endfunction

  function automatic logic isFastZero(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MULDIV_FAST_ZERO_EN
    return o[0] ? (y == '0) : (x == '0 || y == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Timing model: a busy countdown and the pending result of the accepted command.
  int               mBusy = 0;
  logic             mDone = 1'b0;
  logic             mDbz = 1'b0;
  logic [WIDTH-1:0] mHi = '0;
  logic [WIDTH-1:0] mLo = '0;
  logic [WIDTH-1:0] pHi = '0;
  logic [WIDTH-1:0] pLo = '0;
  logic             pDbz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy <= 0;
      mDone <= 1'b0;
      mDbz  <= 1'b0;
      mHi   <= '0;
      mLo   <= '0;
    end else if (mBusy > 0) begin
      mBusy <= mBusy - 1;
      if (mBusy == 1) begin
        mDone <= 1'b1;
        mHi   <= pHi;
        mLo   <= pLo;
        mDbz  <= pDbz;
      end
    end else begin
      mDone <= 1'b0;
      mDbz  <= 1'b0;
      if (start && !op[1]) begin
        if (isFastZero(op, a, b)) begin
          mDone <= 1'b1;
          mHi   <= expHi(op, a, b);
          mLo   <= expLo(op, a, b);
          mDbz  <= op[0] && (b == '0);
        end else begin
          mBusy <= WIDTH;
          pHi   <= expHi(op, a, b);
          pLo   <= expLo(op, a, b);
          pDbz  <= op[0] && (b == '0);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("busy", {63'b0, busy}, {63'b0, (mBusy != 0)});
    checkOutput("done", {63'b0, done}, {63'b0, mDone});
    checkOutput("dbz", {63'b0, div_by_zero}, {63'b0, mDbz});
    checkOutput("hi", {32'b0, hi}, {32'b0, mHi});
    checkOutput("lo", {32'b0, lo}, {32'b0, mLo});
  end

  // Called at a falling edge: start is high until the next falling edge (cycle 0).
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int startN, output int n, output int busyCycles);
    n = startN;
    busyCycles = 0;
    while (!done && n < 100) begin
      if (busy) busyCycles++;
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int bc;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", {63'b0, busy}, 64'd0);
    checkOutput("rstDone", {63'b0, done}, 64'd0);
    checkOutput("rstHi", {32'b0, hi}, 64'd0);
    checkOutput("rstLo", {32'b0, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] MULTU max * max");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(1, n, bc);
    checkOutput("mulLat", n, 64'd33);
    checkOutput("mulBusyCycles", bc, 64'd32);
    checkOutput("mulHi", {32'b0, hi}, 64'hFFFF_FFFE);
    checkOutput("mulLo", {32'b0, lo}, 64'h0000_0001);
    @(negedge clk);

    $display("[TB] DIVU 100 / 7");
    applyStimulus(2'b01, 32'd100, 32'd7);
    checkOutput("divHoldHi", {32'b0, hi}, 64'hFFFF_FFFE);
    checkOutput("divHoldLo", {32'b0, lo}, 64'h0000_0001);
    waitDone(1, n, bc);
    checkOutput("divLat", n, 64'd33);
    checkOutput("divLo", {32'b0, lo}, 64'd14);
    checkOutput("divHi", {32'b0, hi}, 64'd2);
    checkOutput("divDbz", {63'b0, div_by_zero}, 64'd0);
    @(negedge clk);

    $display("[TB] DIVU 5 / 0");
    applyStimulus(2'b01, 32'd5, 32'd0);
    waitDone(1, n, bc);
    checkOutput("div0Lat", n, DIV0_LAT);
    checkOutput("div0Lo", {32'b0, lo}, 64'hFFFF_FFFF);
    checkOutput("div0Hi", {32'b0, hi}, 64'd5);
    checkOutput("div0Dbz", {63'b0, div_by_zero}, 64'd1);
    @(negedge clk);
    checkOutput("div0DbzPulse", {63'b0, div_by_zero}, 64'd0);
    checkOutput("div0DonePulse", {63'b0, done}, 64'd0);

    $display("[TB] MULTU 3*4 with ignored DIVU, then back-to-back DIVU 9/2");
    applyStimulus(2'b00, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    applyStimulus(2'b01, 32'd9, 32'd2);
    waitDone(11, n, bc);
    checkOutput("b2bMulLat", n, 64'd33);
    checkOutput("b2bMulLo", {32'b0, lo}, 64'd12);
    checkOutput("b2bMulHi", {32'b0, hi}, 64'd0);
    applyStimulus(2'b01, 32'd9, 32'd2);
    waitDone(34, n, bc);
    checkOutput("b2bDivLat", n, 64'd66);
    checkOutput("b2bDivLo", {32'b0, lo}, 64'd4);
    checkOutput("b2bDivHi", {32'b0, hi}, 64'd1);
    @(negedge clk);

    $display("[TB] reset during MULTU 6*7");
    applyStimulus(2'b01, 32'h451, 32'h20);
    waitDone(1, n, bc);
    checkOutput("preHi", {32'b0, hi}, 64'h11);
    checkOutput("preLo", {32'b0, lo}, 64'h22);
    @(negedge clk);
    applyStimulus(2'b00, 32'd6, 32'd7);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBusy", {63'b0, busy}, 64'd0);
    checkOutput("midRstDone", {63'b0, done}, 64'd0);
    checkOutput("midRstHi", {32'b0, hi}, 64'd0);
    checkOutput("midRstLo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'b00, 32'd6, 32'd7);
    waitDone(1, n, bc);
    checkOutput("postRstLo", {32'b0, lo}, 64'd42);
    checkOutput("postRstHi", {32'b0, hi}, 64'd0);
    @(negedge clk);

    $display("[TB] no-op command");
    applyStimulus(2'b10, 32'd8, 32'd9);
    checkOutput("nopBusy", {63'b0, busy}, 64'd0);
    checkOutput("nopDone", {63'b0, done}, 64'd0);
    @(negedge clk);
    checkOutput("nopBusy2", {63'b0, busy}, 64'd0);
    checkOutput("nopLo", {32'b0, lo}, 64'd42);
    checkOutput("nopHi", {32'b0, hi}, 64'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
